// File: rtl/l15_resp_pkg.sv
// l15_resp_pkg: request/response encodings and FSM states shared by the line responder.
package l15_resp_pkg;
  localparam int TypeWidth = 3;
  typedef enum logic [TypeWidth-1:0] {
    REQ_LOAD  = 3'd0,
    REQ_IMISS = 3'd1,
    REQ_STORE = 3'd2
  } req_type_e;
  typedef enum logic [TypeWidth-1:0] {
    RSP_ERR       = 3'd0,
    RSP_LOAD_RET  = 3'd1,
    RSP_IFILL_RET = 3'd2,
    RSP_ST_ACK    = 3'd3
  } rsp_type_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_CAP,
    S_WR,
    S_RESP
  } state_e;
  function automatic rsp_type_e rsp_for(input logic [TypeWidth-1:0] t);
    return t == REQ_LOAD  ? RSP_LOAD_RET :
           t == REQ_IMISS ? RSP_IFILL_RET :
           t == REQ_STORE ? RSP_ST_ACK : RSP_ERR;
  endfunction
endpackage

// File: rtl/l15_line_asm.sv
// l15_line_asm: assembles a refill line from two consecutive backing-store words.
module l15_line_asm #(
  parameter int XLEN = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              cap0_i,
  input  logic              cap1_i,
  input  logic [XLEN-1:0]   word_i,
  output logic [2*XLEN-1:0] line_o
);
  logic [XLEN-1:0] w0_q, w1_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      w0_q <= '0;
      w1_q <= '0;
    end else begin
      if (cap0_i) w0_q <= word_i;
      if (cap1_i) w1_q <= word_i;
    end
  end
  assign line_o = {w1_q, w0_q};
endmodule

// File: rtl/l15_line_responder.sv
// l15_line_responder: serves IMISS/LOAD line refills and STORE writes from a word-wide backing store.
module l15_line_responder
  import l15_resp_pkg::*;
#(
  parameter int PAddrWidth    = 40,
  parameter int LineWidth     = 128,
  parameter int XLEN          = 64,
  parameter int SramAddrWidth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_val_i,
  output logic                     req_ack_o,
  input  logic [2:0]               req_type_i,
  input  logic [PAddrWidth-1:0]    req_addr_i,
  input  logic [1:0]               req_tid_i,
  input  logic [XLEN-1:0]          req_data_i,
  input  logic [XLEN/8-1:0]        req_be_i,
  output logic                     rsp_val_o,
  input  logic                     rsp_ack_i,
  output logic [2:0]               rsp_type_o,
  output logic [1:0]               rsp_tid_o,
  output logic [LineWidth-1:0]     rsp_data_o,
  output logic                     sram_req_o,
  output logic                     sram_we_o,
  output logic [SramAddrWidth-1:0] sram_addr_o,
  output logic [XLEN-1:0]          sram_wdata_o,
  output logic [XLEN/8-1:0]        sram_be_o,
  input  logic [XLEN-1:0]          sram_rdata_i
);
  state_e                   state_q, state_d;
  logic [SramAddrWidth-1:0] word_q, line_base;
  logic [XLEN-1:0]          data_q;
  logic [XLEN/8-1:0]        be_q;
  logic [1:0]               tid_q;
  rsp_type_e                rsp_type_q;
  logic                     accept;
  assign accept = rst_ni && state_q == S_IDLE && req_val_i;
  assign req_ack_o = accept;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      data_q     <= '0;
      be_q       <= '0;
      tid_q      <= '0;
      rsp_type_q <= RSP_ERR;
    end else begin
      state_q <= state_d;
      if (accept) begin
        word_q     <= req_addr_i[SramAddrWidth+2:3];
        data_q     <= req_data_i;
        be_q       <= req_be_i;
        tid_q      <= req_tid_i;
        rsp_type_q <= rsp_for(req_type_i);
      end
    end
  end
  // Line fetches are 16-byte aligned, so the pair is {even, even|1}; this wraps naturally.
  assign line_base = {word_q[SramAddrWidth-1:1], 1'b0};
  always_comb begin
    state_d     = state_q;
    sram_req_o  = 1'b0;
    sram_we_o   = 1'b0;
    sram_addr_o = line_base;
    unique case (state_q)
      S_IDLE: if (req_val_i)
        state_d = (req_type_i == REQ_LOAD || req_type_i == REQ_IMISS) ? S_RD0 :
                  req_type_i == REQ_STORE ? S_WR : S_RESP;
      S_RD0: begin
        sram_req_o = 1'b1;
        state_d    = S_RD1;
      end
      S_RD1: begin
        sram_req_o  = 1'b1;
        sram_addr_o = line_base | SramAddrWidth'(1);
        state_d     = S_CAP;
      end
      S_CAP: state_d = S_RESP;
      S_WR: begin
        sram_req_o  = 1'b1;
        sram_we_o   = 1'b1;
        sram_addr_o = word_q;
        state_d     = S_RESP;
      end
      S_RESP: if (rsp_ack_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  assign sram_wdata_o = data_q;
  assign sram_be_o    = be_q;
  assign rsp_val_o    = state_q == S_RESP;
  assign rsp_type_o   = rsp_type_q;
  assign rsp_tid_o    = tid_q;
  l15_line_asm #(.XLEN(XLEN)) u_line_asm (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (accept),
    .cap0_i (state_q == S_RD1),
    .cap1_i (state_q == S_CAP),
    .word_i (sram_rdata_i),
    .line_o (rsp_data_o)
  );
endmodule

// File: tb/tb_l15_line_responder.sv
// tb_l15_line_responder: directed checks of refill, store, backpressure, error and reset behaviour.
module tb_l15_line_responder;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_val = 1'b0, req_ack;
  logic [2:0]   req_type = '0;
  logic [39:0]  req_addr = '0;
  logic [1:0]   req_tid = '0;
  logic [63:0]  req_data = '0;
  logic [7:0]   req_be = '0;
  logic         rsp_val, rsp_ack = 1'b0;
  logic [2:0]   rsp_type;
  logic [1:0]   rsp_tid;
  logic [127:0] rsp_data;
  logic         sram_req, sram_we;
  logic [15:0]  sram_addr;
  logic [63:0]  sram_wdata, sram_rdata = '0;
  logic [7:0]   sram_be;
  int checks = 0, failures = 0;
  logic [63:0] mem [logic [15:0]];

  always #5 clk = ~clk;

  l15_line_responder dut (
    .clk_i(clk), .rst_ni(rst_n), .req_val_i(req_val), .req_ack_o(req_ack),
    .req_type_i(req_type), .req_addr_i(req_addr), .req_tid_i(req_tid),
    .req_data_i(req_data), .req_be_i(req_be), .rsp_val_o(rsp_val),
    .rsp_ack_i(rsp_ack), .rsp_type_o(rsp_type), .rsp_tid_o(rsp_tid),
    .rsp_data_o(rsp_data), .sram_req_o(sram_req), .sram_we_o(sram_we),
    .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_be_o(sram_be),
    .sram_rdata_i(sram_rdata)
  );

  // Backing store: unwritten words read as 0xA000_..._<addr>, read data one cycle after strobe.
  always @(posedge clk) begin : sram_model
    logic [63:0] w;
    if (sram_req) begin
      w = mem.exists(sram_addr) ? mem[sram_addr] : (64'hA000_0000_0000_0000 | 64'(sram_addr));
      if (sram_we) begin
        for (int b = 0; b < 8; b++) if (sram_be[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
        mem[sram_addr] = w;
      end else sram_rdata <= w;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [2:0] ty, input logic [39:0] a, input logic [1:0] tid,
                         input logic [15:0] w0, input logic [127:0] line, input logic [2:0] rt);
    req_type = ty; req_addr = a; req_tid = tid; req_val = 1'b1;
    #1 check("rd_ack_t0", req_ack, 1);
    step(); req_val = 1'b0;
    check("rd_t1_req", {sram_req, sram_we}, 2'b10);
    check("rd_t1_addr", sram_addr, w0);
    check("rd_t1_noack", req_ack, 0);
    step();
    check("rd_t2_req", sram_req, 1);
    check("rd_t2_addr", sram_addr, w0 + 16'd1);
    step();
    check("rd_t3_idle", {sram_req, rsp_val}, 2'b00);
    step();
    check("rd_t4_val", rsp_val, 1);
    check("rd_t4_type", rsp_type, rt);
    check("rd_t4_tid", rsp_tid, tid);
    check("rd_t4_data", rsp_data, line);
    rsp_ack = 1'b1;
    step(); rsp_ack = 1'b0;
    check("rd_done", rsp_val, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    mem[16'h0200] = 64'hA;
    mem[16'h0201] = 64'hB;
    step(); step();
    check("rst_val", rsp_val, 0);
    check("rst_ack", req_ack, 0);
    check("rst_sram", {sram_req, sram_we}, 2'b00);
    check("rst_data", rsp_data, 0);
    check("rst_type_tid", {rsp_type, rsp_tid}, 0);
    rst_n = 1'b1;
    step();
    // LOAD 0x80001008 -> line words 0x200/0x201
    do_read(3'd0, 40'h80001008, 2'd1, 16'h0200, {64'hB, 64'hA}, 3'd1);
    // STORE 0x10, low 4 bytes enabled
    req_type = 3'd2; req_addr = 40'h10; req_tid = 2'd2; req_data = 64'hDEAD; req_be = 8'h0F; req_val = 1'b1;
    #1 check("st_ack_t0", req_ack, 1);
    step(); req_val = 1'b0;
    check("st_t1_strobe", {sram_req, sram_we}, 2'b11);
    check("st_t1_addr", sram_addr, 16'h2);
    check("st_t1_wdata", {sram_wdata, sram_be}, {64'hDEAD, 8'h0F});
    step();
    check("st_t2_rsp", {rsp_val, rsp_type, rsp_tid}, {1'b1, 3'd3, 2'd2});
    check("st_t2_data", rsp_data, 0);
    check("st_t2_nosram", sram_req, 0);
    rsp_ack = 1'b1; step(); rsp_ack = 1'b0;
    do_read(3'd0, 40'h10, 2'd3, 16'h0002, {64'hA000_0000_0000_0003, 64'hA000_0000_0000_DEAD}, 3'd1);
    // Backpressure: IMISS 0x40 held in RESP for 10 cycles with another request pending
    req_type = 3'd1; req_addr = 40'h40; req_tid = 2'd0; req_val = 1'b1;
    #1 check("bp_ack_t0", req_ack, 1);
    step(); req_type = 3'd0; req_addr = 40'h0; req_tid = 2'd2;
    check("bp_t1_noack", req_ack, 0);
    step(); step(); step();
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_val", {rsp_val, rsp_type, rsp_tid}, {1'b1, 3'd2, 2'd0});
      check("bp_hold_data", rsp_data, {64'hA000_0000_0000_0009, 64'hA000_0000_0000_0008});
      check("bp_hold_noack", req_ack, 0);
      step();
    end
    rsp_ack = 1'b1;
    #1 check("bp_ackcyc_noack", req_ack, 0);
    step(); rsp_ack = 1'b0;
    req_val = 1'b0;
    do_read(3'd0, 40'h0, 2'd2, 16'h0000, {64'hA000_0000_0000_0001, 64'hA000_0000_0000_0000}, 3'd1);
    // Unsupported type
    req_type = 3'd7; req_addr = 40'h80; req_tid = 2'd1; req_val = 1'b1;
    #1 check("err_ack_t0", req_ack, 1);
    step(); req_val = 1'b0;
    check("err_t1_nosram", sram_req, 0);
    check("err_t1_rsp", {rsp_val, rsp_type, rsp_tid}, {1'b1, 3'd0, 2'd1});
    check("err_t1_data", rsp_data, 0);
    rsp_ack = 1'b1; step(); rsp_ack = 1'b0;
    // Reset in RD1 with a new request held across it
    req_type = 3'd0; req_addr = 40'h100; req_tid = 2'd1; req_val = 1'b1;
    #1 check("rr_ack_t0", req_ack, 1);
    step(); req_val = 1'b0;
    step();
    check("rr_in_rd1", sram_addr, 16'h0021);
    rst_n = 1'b0; req_addr = 40'h200; req_tid = 2'd3; req_val = 1'b1;
    #1 check("rr_rst_noack", req_ack, 0);
    step();
    check("rr_rst_out", {rsp_val, req_ack, sram_req, sram_we, rsp_type, rsp_tid}, 0);
    check("rr_rst_data", rsp_data, 0);
    step();
    check("rr_rst_noresp", rsp_val, 0);
    rst_n = 1'b1;
    req_val = 1'b0;
    do_read(3'd0, 40'h200, 2'd3, 16'h0040, {64'hA000_0000_0000_0041, 64'hA000_0000_0000_0040}, 3'd1);
    // Back-to-back IMISS at the top of the word space
    do_read(3'd1, 40'hFFFF_FFF0, 2'd0, 16'hFFFE, {64'hA000_0000_0000_FFFF, 64'hA000_0000_0000_FFFE}, 3'd2);
    do_read(3'd1, 40'hFFFF_FFF0, 2'd1, 16'hFFFE, {64'hA000_0000_0000_FFFF, 64'hA000_0000_0000_FFFE}, 3'd2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
